// File: rtl/fd_dram_arbiter_pkg.sv
// rtl/fd_dram_arbiter_pkg.sv - shared types, address map and helpers for the FD DRAM arbiter
package fd_dram_arbiter_pkg;

    localparam logic [16:0] DRAM_BASE_ADDR = 17'h10000;
    localparam int          REC_BYTES      = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        RESP
    } ARB_STATE;

    typedef struct packed {
        logic [31:0] res_info;
        logic [31:0] D_man_Info;
    } Dram_data;

    // Byte address of a record; 17 bits holds the full id range without overflow.
    function automatic logic [16:0] rec_addr(input logic [7:0] id);
        return DRAM_BASE_ADDR + 17'(id) * 17'(REC_BYTES);
    endfunction

endpackage

// File: rtl/fd_rr_picker.sv
// rtl/fd_rr_picker.sv - combinational 2-way grant; FD_ARB_RR_EN selects round-robin over fixed priority
module fd_rr_picker (
    input  logic [1:0] req_valid,
`ifdef FD_ARB_RR_EN
    input  logic       rr_last,
`endif
    output logic       gnt_any,
    output logic       gnt_idx
);

    always_comb begin
        gnt_any = |req_valid;
`ifdef FD_ARB_RR_EN
        if (&req_valid) begin
            gnt_idx = ~rr_last;
        end else begin
            gnt_idx = req_valid[1];
        end
`else
        gnt_idx = ~req_valid[0];
`endif
    end

endmodule

// File: rtl/fd_dram_arbiter.sv
// rtl/fd_dram_arbiter.sv - serialises two FD requesters onto one AXI4-Lite DRAM bridge (FD_ARB_RR_EN: round-robin)
module fd_dram_arbiter
    import fd_dram_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_we,
    input  logic [1:0][7:0]  req_id,
    input  Dram_data [1:0]   req_wdata,
    output logic [1:0]       rsp_valid,
    output Dram_data         rsp_rdata,
    output logic             rsp_err,
    output logic             ar_valid,
    input  logic             ar_ready,
    output logic [16:0]      ar_addr,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [63:0]      r_data,
    input  logic [1:0]       r_resp,
    output logic             aw_valid,
    input  logic             aw_ready,
    output logic [16:0]      aw_addr,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [63:0]      w_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_resp
);

    ARB_STATE    state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [16:0] addr_q, addr_d;
    Dram_data    wdata_q, wdata_d;
    Dram_data    rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        gnt_any, gnt_idx;

`ifdef FD_ARB_RR_EN
    logic        rr_last_q, rr_last_d;

    fd_rr_picker u_picker (
        .req_valid (req_valid),
        .rr_last   (rr_last_q),
        .gnt_any   (gnt_any),
        .gnt_idx   (gnt_idx)
    );
`else
    fd_rr_picker u_picker (
        .req_valid (req_valid),
        .gnt_any   (gnt_any),
        .gnt_idx   (gnt_idx)
    );
`endif

    assign ar_addr   = addr_q;
    assign aw_addr   = addr_q;
    assign w_data    = wdata_q;
    assign rsp_rdata = rdata_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef FD_ARB_RR_EN
        rr_last_d = rr_last_q;
`endif
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        rsp_err   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    req_ready[gnt_idx] = 1'b1;
                    gnt_d     = gnt_idx;
                    addr_d    = rec_addr(req_id[gnt_idx]);
                    wdata_d   = req_wdata[gnt_idx];
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef FD_ARB_RR_EN
                    rr_last_d = gnt_idx;
`endif
                    state_d   = req_we[gnt_idx] ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            RD_ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    rdata_d = r_data;
                    err_d   = |r_resp;
                    state_d = RESP;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently; each valid drops after its own handshake.
                aw_valid = ~aw_done_q;
                w_valid  = ~w_done_q;
                if (!aw_done_q && aw_ready) aw_done_d = 1'b1;
                if (!w_done_q && w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)  state_d   = WR_RESP;
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    err_d   = |b_resp;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                rsp_err          = err_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef FD_ARB_RR_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef FD_ARB_RR_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_fd_dram_arbiter.sv
// tb/tb_fd_dram_arbiter.sv - self-checking bench: vector table, corner sequences, random traffic vs memory model
`timescale 1ns/1ps
module tb_fd_dram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       req_valid = '0, req_we = '0;
    logic [1:0][7:0]  req_id = '0;
    logic [1:0][63:0] req_wdata = '0;
    logic [1:0]       req_ready, rsp_valid;
    logic [63:0]      rsp_rdata;
    logic             rsp_err;
    logic             ar_valid, r_ready, aw_valid, w_valid, b_ready;
    logic [16:0]      ar_addr, aw_addr;
    logic [63:0]      w_data;
    logic             ar_ready = 1'b0, r_valid = 1'b0, aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0;
    logic [63:0]      r_data = '0;
    logic [1:0]       r_resp = '0, b_resp = '0;

    fd_dram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_id(req_id),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    int checks = 0, errors = 0;
    int last_grant = 1;
    logic [63:0] dram [256];
    logic [63:0] ref_mem [256];

    // Slave: fixed per-channel wait counts, readies/valids changed on the falling edge.
    int cfg_ar_d = 0, cfg_r_d = 0, cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0;
    logic [1:0] cfg_resp = 2'b00;
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    int ar_hs_n = 0, r_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
    logic r_pend = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
    logic [16:0] rd_addr = '0, wr_addr = '0;
    logic [63:0] wr_data = '0;

    function automatic int aidx(input logic [16:0] a);
        return int'((a - 17'h10000) >> 3) & 255;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
            r_pend = 0; aw_seen = 0; w_seen = 0;
            ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        end else begin
            if (b_valid) begin
                b_valid = 0; b_hs_n++;
            end else if (aw_seen && w_seen) begin
                if (b_wait >= cfg_b_d) begin
                    b_valid = 1; b_resp = cfg_resp; dram[aidx(wr_addr)] = wr_data;
                    aw_seen = 0; w_seen = 0; b_wait = 0;
                end else b_wait++;
            end
            if (r_valid) begin
                r_valid = 0; r_hs_n++;
            end else if (r_pend) begin
                if (r_wait >= cfg_r_d) begin
                    r_valid = 1; r_data = dram[aidx(rd_addr)]; r_resp = cfg_resp;
                    r_pend = 0; r_wait = 0;
                end else r_wait++;
            end
            ar_ready = 0;
            if (ar_valid) begin
                if (ar_wait >= cfg_ar_d) begin
                    ar_ready = 1; rd_addr = ar_addr; ar_hs_n++; r_pend = 1; ar_wait = 0;
                end else ar_wait++;
            end
            aw_ready = 0;
            if (aw_valid) begin
                if (aw_wait >= cfg_aw_d) begin
                    aw_ready = 1; wr_addr = aw_addr; aw_seen = 1; aw_hs_n++; aw_wait = 0;
                end else aw_wait++;
            end
            w_ready = 0;
            if (w_valid) begin
                if (w_wait >= cfg_w_d) begin
                    w_ready = 1; wr_data = w_data; w_seen = 1; w_hs_n++; w_wait = 0;
                end else w_wait++;
            end
        end
    end

    typedef struct {
        int          port;
        logic        we;
        logic [7:0]  id;
        logic [63:0] wdata;
        logic        preload;
        logic [63:0] pre;
        logic [1:0]  resp;
        int          ar_d, r_d, aw_d, w_d, b_d;
        logic [16:0] exp_addr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic issue(input int p, input logic we, input logic [7:0] id, input logic [63:0] wd);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            req_we[p] = we; req_id[p] = id; req_wdata[p] = wd; req_valid[p] = 1'b1;
            #1;
            if (req_ready != 2'b00) break;
        end
        chk("grant", 64'(req_ready), 64'(onehot(p)));
        last_grant = p;
    endtask

    task automatic wait_rsp(input int p, output int lat);
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) req_valid[p] = 1'b0;
            #1;
            if (rsp_valid != 2'b00) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_vec(input vec_t v);
        int lat, exp_lat, a0, r0, aw0, w0, b0;
        cfg_ar_d = v.ar_d; cfg_r_d = v.r_d; cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d;
        cfg_resp = v.resp;
        if (v.preload) begin
            dram[v.id] = v.pre; ref_mem[v.id] = v.pre;
        end
        a0 = ar_hs_n; r0 = r_hs_n; aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
        issue(v.port, v.we, v.id, v.wdata);
        wait_rsp(v.port, lat);
        exp_lat = v.we ? (((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d + 3) : (v.ar_d + v.r_d + 3);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_valid", 64'(rsp_valid), 64'(onehot(v.port)));
        chk("rsp_err", 64'(rsp_err), 64'(v.resp != 2'b00));
        if (v.we) begin
            chk("aw_addr", 64'(wr_addr), 64'(v.exp_addr));
            chk("w_data", wr_data, v.wdata);
            chk("wr_handshakes", 64'({aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0}), 64'({32'd1, 32'd1, 32'd1}));
            ref_mem[v.id] = v.wdata;
        end else begin
            chk("ar_addr", 64'(rd_addr), 64'(v.exp_addr));
            chk("rsp_rdata", rsp_rdata, ref_mem[v.id]);
            chk("rd_handshakes", 64'({ar_hs_n - a0, r_hs_n - r0}), 64'({32'd1, 32'd1}));
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, 64'({req_ready, rsp_valid, rsp_err, ar_valid, r_ready, aw_valid, w_valid, b_ready}), 64'd0);
        chk({name, "_addr"}, 64'({ar_addr, aw_addr}), 64'd0);
        chk({name, "_data"}, rsp_rdata | w_data, 64'd0);
    endtask

    vec_t tbl [7];

    initial begin
        int lat, bad_ar, bad_rdy, gi, ri, upd, lg;
        int rem [2];
        int exp_g [8];
        int got_g [8];
        logic [7:0] idq [$];
        logic seen;
        vec_t v;

        for (int i = 0; i < 256; i++) begin
            dram[i] = {$urandom, $urandom};
            ref_mem[i] = dram[i];
        end
        tbl[0] = '{0, 1'b0, 8'h00, 64'h0, 1'b1, 64'hDEAD_BEEF_0123_4567, 2'b00, 0, 0, 0, 0, 0, 17'h10000};
        tbl[1] = '{1, 1'b1, 8'hFF, 64'h1, 1'b0, 64'h0, 2'b00, 0, 0, 3, 0, 0, 17'h107F8};
        tbl[2] = '{0, 1'b0, 8'hFF, 64'h0, 1'b0, 64'h0, 2'b00, 0, 0, 0, 0, 0, 17'h107F8};
        tbl[3] = '{1, 1'b0, 8'h10, 64'h0, 1'b0, 64'h0, 2'b10, 0, 0, 0, 0, 0, 17'h10080};
        tbl[4] = '{1, 1'b0, 8'h10, 64'h0, 1'b0, 64'h0, 2'b00, 0, 0, 0, 0, 0, 17'h10080};
        tbl[5] = '{0, 1'b1, 8'h07, 64'h0BAD_F00D_55AA_1234, 1'b0, 64'h0, 2'b11, 0, 0, 1, 2, 2, 17'h10038};
        tbl[6] = '{0, 1'b0, 8'h07, 64'h0, 1'b0, 64'h0, 2'b00, 1, 4, 0, 0, 0, 17'h10038};

        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk); #2; rst_n = 1'b1;

        foreach (tbl[i]) do_vec(tbl[i]);

        // Both ports requesting reads every cycle, four each.
        cfg_ar_d = 0; cfg_r_d = 0; cfg_resp = 2'b00;
        rem[0] = 4; rem[1] = 4; lg = last_grant;
        for (int k = 0; k < 8; k++) begin
            if (rem[0] > 0 && rem[1] > 0) begin
`ifdef FD_ARB_RR_EN
                exp_g[k] = 1 - lg;
`else
                exp_g[k] = 0;
`endif
            end else begin
                exp_g[k] = (rem[0] > 0) ? 0 : 1;
            end
            rem[exp_g[k]]--;
            lg = exp_g[k];
        end
        rem[0] = 4; rem[1] = 4; gi = 0; ri = 0; upd = -1;
        @(negedge clk);
        req_we = 2'b00; req_id[0] = 8'h50; req_id[1] = 8'h60; req_valid = 2'b11;
        for (int cyc = 0; cyc < 300 && ri < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (upd >= 0) begin
                rem[upd]--;
                if (rem[upd] == 0) req_valid[upd] = 1'b0;
                else req_id[upd] = req_id[upd] + 8'd1;
                upd = -1;
            end
            #1;
            if (rsp_valid != 2'b00 && ri < gi) begin
                chk("rr_rsp_port", 64'(rsp_valid), 64'(onehot(got_g[ri])));
                chk("rr_rsp_rdata", rsp_rdata, ref_mem[idq.pop_front()]);
                ri++;
            end
            if (req_ready != 2'b00 && gi < 8) begin
                got_g[gi] = req_ready[1] ? 1 : 0;
                idq.push_back(req_id[got_g[gi]]);
                chk("rr_grant_order", 64'(got_g[gi]), 64'(exp_g[gi]));
                last_grant = got_g[gi];
                upd = got_g[gi];
                gi++;
            end
        end
        chk("rr_counts", 64'({gi, ri}), 64'({32'd8, 32'd8}));
        req_valid = 2'b00;

        // Async reset while waiting for the write response.
        cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 40; cfg_resp = 2'b00;
        issue(1, 1'b1, 8'h22, 64'hCAFE_0000_1111_2222);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n == 0) req_valid[1] = 1'b0;
            #1;
            if (b_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_reached_wr_resp", 64'(seen), 64'd1);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        chk_all_zero("async_reset");
        @(negedge clk); @(negedge clk); #2; rst_n = 1'b1; last_grant = 1;
        bad_rdy = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #1;
            if (rsp_valid != 2'b00) bad_rdy++;
        end
        chk("rst_no_rsp", 64'(bad_rdy), 64'd0);
        v = '{0, 1'b0, 8'h22, 64'h0, 1'b0, 64'h0, 2'b00, 0, 0, 0, 0, 0, 17'h10110};
        do_vec(v);

        // Long AR stall with port 1 waiting.
        cfg_ar_d = 50; cfg_r_d = 0; cfg_resp = 2'b00;
        issue(0, 1'b0, 8'h33, 64'h0);
        bad_ar = 0; bad_rdy = 0; lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_valid[0] = 1'b0; req_we[1] = 1'b0; req_id[1] = 8'h44; req_valid[1] = 1'b1;
            end
            #1;
            if (rsp_valid != 2'b00) begin
                lat = n;
                break;
            end
            if (req_ready != 2'b00) bad_rdy++;
            if (n <= 51 && (!ar_valid || ar_addr != 17'h10198)) bad_ar++;
        end
        chk("stall_ar_stable", 64'(bad_ar), 64'd0);
        chk("stall_port1_blocked", 64'(bad_rdy), 64'd0);
        chk("stall_latency", 64'(lat), 64'd53);
        chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("stall_rdata", rsp_rdata, ref_mem[8'h33]);
        cfg_ar_d = 0;
        issue(1, 1'b0, 8'h44, 64'h0);
        wait_rsp(1, lat);
        chk("after_stall_latency", 64'(lat), 64'd3);
        chk("after_stall_rdata", rsp_rdata, ref_mem[8'h44]);

        // Random single-port traffic against the memory model.
        for (int k = 0; k < 40; k++) begin
            v.port = int'($urandom_range(1, 0));
            v.we = 1'($urandom_range(1, 0));
            v.id = 8'($urandom);
            v.wdata = {$urandom, $urandom};
            v.preload = 1'b0;
            v.pre = 64'h0;
            v.resp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            v.ar_d = int'($urandom_range(3, 0)); v.r_d = int'($urandom_range(3, 0));
            v.aw_d = int'($urandom_range(3, 0)); v.w_d = int'($urandom_range(3, 0));
            v.b_d = int'($urandom_range(3, 0));
            v.exp_addr = 17'(32'h10000 + 32'(v.id) * 8);
            do_vec(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
